// File: rtl/updown_sweep_ctrl.sv
// updown_sweep_ctrl: sequences an up/down counter through programmed start->end sweeps with repeats.
// Define SWEEP_CTRL_BOUNCE_EN to honour cmd_bounce (ping-pong passes); otherwise every pass reloads start.
module updown_sweep_ctrl #(
  parameter int WIDTH = 8,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_start,
  input  logic [WIDTH-1:0] cmd_end,
  input  logic [REP_W-1:0] cmd_reps,
  input  logic             cmd_bounce,
  input  logic             cmd_abort,
  output logic             cnt_en,
  output logic             cnt_m,
  output logic             cnt_load,
  output logic [WIDTH-1:0] cnt_data,
  input  logic [WIDTH-1:0] cnt_count,
  output logic             busy,
  output logic             done,
  output logic [REP_W:0]   pass_cnt
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] origin, target, data_q;
  logic [REP_W-1:0] left;
  logic dir, hit, last, swap, accept;
  assign accept = cmd_valid && state == IDLE;
  assign hit = state == RUN && cnt_count == target;
  assign last = left == '0;
`ifdef SWEEP_CTRL_BOUNCE_EN
  logic bounce;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) bounce <= 1'b0;
    else if (accept) bounce <= cmd_bounce;
  assign swap = hit && !last && bounce;
`else
  logic unused_bounce;
  assign unused_bounce = cmd_bounce;
  assign swap = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = cmd_valid ? LOAD : IDLE;
      LOAD: state_nx = RUN;
      RUN:  state_nx = !hit ? RUN : last ? DONE : swap ? RUN : LOAD;
      DONE: state_nx = IDLE;
    endcase
    if (cmd_abort && state != IDLE) state_nx = IDLE;
  end
  // On a bounce turnaround the detect cycle already drives the next pass toward the old origin.
  always_comb begin
    cmd_ready = state == IDLE;
    busy = state != IDLE;
    cnt_load = state == LOAD && !cmd_abort;
    cnt_en = state == RUN && !cmd_abort && cnt_count != (swap ? origin : target);
    cnt_m = state == RUN && (dir ^ swap);
    cnt_data = state == LOAD ? origin : data_q;
    done = state == DONE && !cmd_abort;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      origin <= '0;
      target <= '0;
      data_q <= '0;
      left <= '0;
      dir <= 1'b0;
      pass_cnt <= '0;
    end else begin
      if (accept) begin
        origin <= cmd_start;
        target <= cmd_end;
        left <= cmd_reps;
        pass_cnt <= '0;
      end
      if (state == LOAD) begin
        dir <= target < origin;
        data_q <= origin;
      end
      if (hit && !cmd_abort) begin
        pass_cnt <= pass_cnt + 1'b1;
        if (!last) left <= left - 1'b1;
        if (swap) begin
          origin <= target;
          target <= origin;
          dir <= ~dir;
        end
      end
    end
endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// tb_updown_sweep_ctrl: directed and random sweeps against a per-cycle trajectory model plus a counter model.
module tb_updown_sweep_ctrl;
  logic clk = 0, rst_n = 0;
  logic cmd_valid = 0, cmd_ready, cmd_bounce = 0, cmd_abort = 0;
  logic [7:0] cmd_start = 0, cmd_end = 0, cnt_data, cnt_count;
  logic [3:0] cmd_reps = 0;
  logic cnt_en, cnt_m, cnt_load, busy, done;
  logic [4:0] pass_cnt;
  int cmps = 0, errs = 0;
`ifdef SWEEP_CTRL_BOUNCE_EN
  localparam bit BOUNCE = 1'b1;
`else
  localparam bit BOUNCE = 1'b0;
`endif

  updown_sweep_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_end(cmd_end), .cmd_reps(cmd_reps), .cmd_bounce(cmd_bounce),
    .cmd_abort(cmd_abort), .cnt_en(cnt_en), .cnt_m(cnt_m), .cnt_load(cnt_load),
    .cnt_data(cnt_data), .cnt_count(cnt_count), .busy(busy), .done(done), .pass_cnt(pass_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_count <= 8'd0;
    else if (cnt_load) cnt_count <= cnt_data;
    else if (cnt_en) cnt_count <= cnt_m ? cnt_count - 8'd1 : cnt_count + 8'd1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    cmps++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, cmd_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_en"}, cnt_en, 0);
    chk({tag, "_m"}, cnt_m, 0);
    chk({tag, "_load"}, cnt_load, 0);
    chk({tag, "_data"}, cnt_data, 0);
    chk({tag, "_pass"}, pass_cnt, 0);
  endtask

  // Called just after a negedge; returns just after the negedge of the first idle cycle.
  task automatic run_cmd(input int s, input int e, input int r, input bit b,
                         input bit hold = 0, input int hs = 0, input int he = 0,
                         input int hr = 0, input bit hb = 0);
    int q_cnt[$];
    bit q_ld[$], q_dn[$];
    int v, dest, passes;
    bit bo;
    passes = r + 1;
    bo = b && BOUNCE;
    q_ld.push_back(1); q_cnt.push_back(-1); q_dn.push_back(0);
    if (bo) begin
      v = s;
      q_ld.push_back(0); q_cnt.push_back(v); q_dn.push_back(0);
      for (int p = 0; p < passes; p++) begin
        dest = (p % 2 == 0) ? e : s;
        while (v != dest) begin
          v += (dest > v) ? 1 : -1;
          q_ld.push_back(0); q_cnt.push_back(v); q_dn.push_back(0);
        end
      end
      q_ld.push_back(0); q_cnt.push_back(v); q_dn.push_back(1);
    end else begin
      for (int p = 0; p < passes; p++) begin
        if (p > 0) begin
          q_ld.push_back(1); q_cnt.push_back(e); q_dn.push_back(0);
        end
        v = s;
        q_ld.push_back(0); q_cnt.push_back(v); q_dn.push_back(0);
        while (v != e) begin
          v += (e > v) ? 1 : -1;
          q_ld.push_back(0); q_cnt.push_back(v); q_dn.push_back(0);
        end
      end
      q_ld.push_back(0); q_cnt.push_back(e); q_dn.push_back(1);
    end
    cmd_start = s[7:0]; cmd_end = e[7:0]; cmd_reps = r[3:0]; cmd_bounce = b; cmd_valid = 1;
    chk("accept_ready", cmd_ready, 1);
    @(posedge clk);
    for (int i = 0; i < q_cnt.size(); i++) begin
      @(negedge clk);
      if (i == 0) begin
        if (hold) begin
          cmd_start = hs[7:0]; cmd_end = he[7:0]; cmd_reps = hr[3:0]; cmd_bounce = hb;
        end else cmd_valid = 0;
      end
      chk($sformatf("load_c%0d", i + 1), cnt_load, q_ld[i]);
      chk($sformatf("done_c%0d", i + 1), done, q_dn[i]);
      chk($sformatf("ready_c%0d", i + 1), cmd_ready, 0);
      if (q_cnt[i] >= 0) chk($sformatf("count_c%0d", i + 1), cnt_count, q_cnt[i]);
      if (q_ld[i]) chk($sformatf("ldata_c%0d", i + 1), cnt_data, s);
      if (q_dn[i]) chk("pass_at_done", pass_cnt, passes);
    end
    @(negedge clk);
    chk("idle_ready", cmd_ready, 1);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_pass", pass_cnt, passes);
    chk("idle_en", cnt_en, 0);
  endtask

  initial begin
    int s, e, r, found;
    bit b;
    #2;
    chk_reset_vals("rst");
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    chk_reset_vals("post_rst");
    chk("post_rst_count", cnt_count, 0);
    run_cmd(5, 8, 0, 0);
    run_cmd(10, 7, 0, 0);
    run_cmd(2, 4, 1, 1);
    run_cmd(2, 4, 1, 0);
    run_cmd(9, 9, 0, 0);
    run_cmd(250, 255, 0, 0);
    run_cmd(3, 0, 2, 1);
    // Abort mid-sweep.
    cmd_start = 5; cmd_end = 200; cmd_reps = 0; cmd_bounce = 0; cmd_valid = 1;
    @(posedge clk); @(negedge clk); cmd_valid = 0;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (cnt_count == 8'd6) found = 1;
    end
    chk("abort_reach6", found, 1);
    cmd_abort = 1; #1;
    chk("abort_en", cnt_en, 0);
    chk("abort_load", cnt_load, 0);
    chk("abort_done", done, 0);
    @(negedge clk); cmd_abort = 0;
    chk("abort_ready", cmd_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done_next", done, 0);
    chk("abort_count", cnt_count, 6);
    @(negedge clk);
    chk("abort_count_hold", cnt_count, 6);
    chk("abort_done_hold", done, 0);
    cmd_abort = 1;
    @(negedge clk); cmd_abort = 0;
    chk("idle_abort_ready", cmd_ready, 1);
    run_cmd(6, 9, 0, 0);
    // Asynchronous reset mid-sweep.
    cmd_start = 5; cmd_end = 200; cmd_reps = 0; cmd_valid = 1;
    @(posedge clk); @(negedge clk); cmd_valid = 0;
    repeat (5) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    #2 rst_n = 0; #1;
    chk_reset_vals("midrst");
    chk("midrst_count", cnt_count, 0);
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    run_cmd(3, 6, 0, 0);
    // Command held valid during a sweep starts right after done.
    run_cmd(20, 23, 1, 0, 1, 30, 27, 0, 0);
    run_cmd(30, 27, 0, 0);
    for (int k = 0; k < 20; k++) begin
      s = $urandom_range(0, 255);
      e = s + $urandom_range(0, 24) - 12;
      if (e < 0) e = 0;
      if (e > 255) e = 255;
      r = $urandom_range(0, 3);
      b = $urandom_range(0, 1);
      if (b && s == e) e = s ^ 1;
      run_cmd(s, e, r, b);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end
endmodule
